// File: rtl/eth_link_pkg.sv
// Shared constants, state encodings and frame byte helper
// for the ETH-side console fs/fd command link.
package eth_link_pkg;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hAA;
    localparam int         FRAME_LEN = 6;

    localparam logic [2:0] IDX_H0   = 3'd0;
    localparam logic [2:0] IDX_H1   = 3'd1;
    localparam logic [2:0] IDX_TYPE = 3'd2;
    localparam logic [2:0] IDX_B3   = 3'd3;
    localparam logic [2:0] IDX_B4   = 3'd4;
    localparam logic [2:0] IDX_CHK  = 3'd5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_H1,
        RX_TYPE,
        RX_CMDH,
        RX_CMDL,
        RX_CHK
    } rx_state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_POST,
        HS_WAIT_LO
    } hs_state_t;

    // Byte at position idx of a frame; CHK covers bytes 2..4.
    function automatic logic [7:0] frame_byte(
        input logic [2:0] idx,
        input logic [7:0] h0,
        input logic [7:0] h1,
        input logic [3:0] btype,
        input logic [7:0] b3,
        input logic [7:0] b4
    );
        logic [7:0] r;
        case (idx)
            IDX_H0:   r = h0;
            IDX_H1:   r = h1;
            IDX_TYPE: r = {4'h0, btype};
            IDX_B3:   r = b3;
            IDX_B4:   r = b4;
            default:  r = {4'h0, btype} ^ b3 ^ b4;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/eth_link_if.sv
// Console fs/fd handshake plus MAC byte streams.
// slave = link endpoint view, master = console/MAC view.
interface eth_link_if;

    logic        fs_send;
    logic        fd_send;
    logic [3:0]  send_btype;
    logic        fs_read;
    logic        fd_read;
    logic [3:0]  read_btype;
    logic [15:0] com_cmd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  fs_send, send_btype, fd_read,
        input  rx_data, rx_valid, tx_ready,
        output fd_send, fs_read, read_btype, com_cmd,
        output tx_data, tx_valid
    );

    modport master (
        output fs_send, send_btype, fd_read,
        output rx_data, rx_valid, tx_ready,
        input  fd_send, fs_read, read_btype, com_cmd,
        input  tx_data, tx_valid
    );

endinterface

// File: rtl/eth_link_tx.sv
// Six-byte status frame serialiser with valid/ready output.
// done pulses combinationally on the last byte handshake.
module eth_link_tx
    import eth_link_pkg::*;
#(
    parameter logic [7:0] HEAD0 = HEAD0_DEF,
    parameter logic [7:0] HEAD1 = HEAD1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] btype,
    input  logic [7:0] seq,
    output logic       done,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    logic [2:0] idx;
    logic [3:0] bt_q;
    logic [7:0] seq_q;

    assign done = tx_valid && tx_ready && (idx == IDX_CHK);

    // Load the frame on start, step one byte per accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            bt_q     <= '0;
            seq_q    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (start && !tx_valid) begin
            idx      <= IDX_H0;
            bt_q     <= btype;
            seq_q    <= seq;
            tx_data  <= HEAD0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            if (idx == IDX_CHK) begin
                idx      <= IDX_H0;
                tx_valid <= 1'b0;
            end else begin
                idx     <= idx + 3'd1;
                tx_data <= frame_byte(idx + 3'd1, HEAD0, HEAD1,
                                      bt_q, seq_q, 8'h00);
            end
        end
    end

endmodule

// File: rtl/eth_console_link.sv
// ETH-side endpoint of the console fs/fd command link.
// Optional error counter: define ETH_LINK_STAT_EN.
module eth_console_link
    import eth_link_pkg::*;
#(
    parameter logic [7:0]  HEAD0   = HEAD0_DEF,
    parameter logic [7:0]  HEAD1   = HEAD1_DEF,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    eth_link_if.slave   bus
`ifdef ETH_LINK_STAT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

    tx_state_t   tx_st;
    rx_state_t   p_st;
    hs_state_t   hs_st;
    logic [7:0]  seq;
    logic        tx_done;
    logic        tx_start;
    logic [15:0] to_cnt;
    logic [3:0]  sh_type;
    logic [15:0] sh_cmd;
    logic        chk_ok;
    logic        frame_good;
    logic        load;
    logic        timeout_hit;

    assign tx_start = (tx_st == TX_IDLE) && bus.fs_send;

    eth_link_tx #(
        .HEAD0 (HEAD0),
        .HEAD1 (HEAD1)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (tx_start),
        .btype    (bus.send_btype),
        .seq      (seq),
        .done     (tx_done),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid),
        .tx_ready (bus.tx_ready)
    );

    // Send request sequencing: fd_send held until fs_send drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st       <= TX_IDLE;
            bus.fd_send <= 1'b0;
            seq         <= '0;
        end else begin
            unique case (tx_st)
                TX_IDLE: if (bus.fs_send) tx_st <= TX_SEND;
                TX_SEND: if (tx_done) begin
                    bus.fd_send <= 1'b1;
                    seq         <= seq + 8'd1;
                    tx_st       <= TX_DONE;
                end
                TX_DONE: if (!bus.fs_send) begin
                    bus.fd_send <= 1'b0;
                    tx_st       <= TX_IDLE;
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    assign chk_ok = bus.rx_data ==
        ({4'h0, sh_type} ^ sh_cmd[15:8] ^ sh_cmd[7:0]);
    assign frame_good  = bus.rx_valid && (p_st == RX_CHK) && chk_ok;
    assign load        = frame_good && (hs_st == HS_IDLE);
    assign timeout_hit = !bus.rx_valid && (p_st != RX_IDLE) &&
                         (to_cnt == TO_LAST);

    // Frame parser into shadow registers with inter-byte timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_st    <= RX_IDLE;
            to_cnt  <= '0;
            sh_type <= '0;
            sh_cmd  <= '0;
        end else if (bus.rx_valid) begin
            to_cnt <= '0;
            unique case (p_st)
                RX_IDLE: if (bus.rx_data == HEAD0) p_st <= RX_H1;
                RX_H1: begin
                    if (bus.rx_data == HEAD1)      p_st <= RX_TYPE;
                    else if (bus.rx_data == HEAD0) p_st <= RX_H1;
                    else                           p_st <= RX_IDLE;
                end
                RX_TYPE: begin
                    if (bus.rx_data[7:4] != 4'h0) begin
                        p_st <= RX_IDLE;
                    end else begin
                        sh_type <= bus.rx_data[3:0];
                        p_st    <= RX_CMDH;
                    end
                end
                RX_CMDH: begin
                    sh_cmd[15:8] <= bus.rx_data;
                    p_st         <= RX_CMDL;
                end
                RX_CMDL: begin
                    sh_cmd[7:0] <= bus.rx_data;
                    p_st        <= RX_CHK;
                end
                default: p_st <= RX_IDLE;
            endcase
        end else if (p_st == RX_IDLE) begin
            to_cnt <= '0;
        end else if (timeout_hit) begin
            to_cnt <= '0;
            p_st   <= RX_IDLE;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // Console read handshake; outputs frozen while fs_read is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_st          <= HS_IDLE;
            bus.fs_read    <= 1'b0;
            bus.read_btype <= '0;
            bus.com_cmd    <= '0;
        end else begin
            unique case (hs_st)
                HS_IDLE: if (load) begin
                    bus.read_btype <= sh_type;
                    bus.com_cmd    <= sh_cmd;
                    bus.fs_read    <= 1'b1;
                    hs_st          <= HS_POST;
                end
                HS_POST: if (bus.fd_read) begin
                    bus.fs_read <= 1'b0;
                    hs_st       <= HS_WAIT_LO;
                end
                HS_WAIT_LO: if (!bus.fd_read) hs_st <= HS_IDLE;
                default: hs_st <= HS_IDLE;
            endcase
        end
    end

`ifdef ETH_LINK_STAT_EN
    logic err;

    // One error event per cycle at most; the parser is the only source.
    always_comb begin
        err = 1'b0;
        if (bus.rx_valid) begin
            if (p_st == RX_TYPE)
                err = bus.rx_data[7:4] != 4'h0;
            else if (p_st == RX_CHK)
                err = !chk_ok || (hs_st != HS_IDLE);
        end else begin
            err = timeout_hit;
        end
    end

    // Saturating error counter, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    // Without statistics, bad frames are simply discarded by the parser.
`endif

endmodule

// File: tb/tb_eth_console_link.sv
// Self-checking bench for eth_console_link: vector tables,
// directed corner cases and randomized frames vs a frame-level model.
module tb_eth_console_link;

    localparam logic [15:0] TO = 16'd40;

    typedef struct {
        logic [47:0] frame;
        bit          ok;
        logic [3:0]  bt;
        logic [15:0] cmd;
    } rx_vec_t;

    typedef struct {
        logic [3:0] bt;
        int         mode;
    } tx_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_link_if bus();

`ifdef ETH_LINK_STAT_EN
    logic [7:0] err_cnt;
`endif

    eth_console_link #(
        .HEAD0   (8'h55),
        .HEAD1   (8'hAA),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ETH_LINK_STAT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int err_m  = 0;
    logic [7:0] seq_m = 8'h00;
    int rdy_mode = 0;
    logic [7:0] txq[$];

    task automatic chk(input string name, input logic [47:0] got,
                       input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_err();
`ifdef ETH_LINK_STAT_EN
        chk("err_cnt", 48'(err_cnt), 48'(err_m));
`endif
    endtask

    function automatic logic [47:0] mk(input logic [3:0] bt,
                                       input logic [15:0] cmd);
        logic [7:0] c;
        c = {4'h0, bt} ^ cmd[15:8] ^ cmd[7:0];
        return {8'h55, 8'hAA, 4'h0, bt, cmd, c};
    endfunction

    function automatic bit ok_of(input logic [47:0] f);
        return f[47:40] == 8'h55 && f[39:32] == 8'hAA &&
               f[31:28] == 4'h0 &&
               f[7:0] == (f[31:24] ^ f[23:16] ^ f[15:8]);
    endfunction

    // MAC ready pattern: always, alternating, or random.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: bus.tx_ready = 1'b1;
                1: bus.tx_ready = ~bus.tx_ready;
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Collect accepted TX bytes using values settled before the edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.tx_valid && bus.tx_ready)
                txq.push_back(bus.tx_data);
        end
    end

    task automatic feed_q(input logic [7:0] bq[$]);
        foreach (bq[i]) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = bq[i];
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic feed(input logic [47:0] f);
        logic [7:0] bq[$];
        for (int i = 5; i >= 0; i--) bq.push_back(f[i*8 +: 8]);
        feed_q(bq);
    endtask

    task automatic check_rx(input string name, input bit ok,
                            input logic [3:0] bt, input logic [15:0] cmd);
        chk({name, ".fs_read"}, 48'(bus.fs_read), 48'(ok));
        if (ok) begin
            chk({name, ".btype"}, 48'(bus.read_btype), 48'(bt));
            chk({name, ".cmd"}, 48'(bus.com_cmd), 48'(cmd));
            bus.fd_read = 1'b1;
            @(negedge clk);
            chk({name, ".fs_read_lo"}, 48'(bus.fs_read), 48'h0);
            bus.fd_read = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_send(input string name, input logic [3:0] bt);
        logic [47:0] exp;
        logic [47:0] got;
        int n;
        txq.delete();
        bus.fs_send    = 1'b1;
        bus.send_btype = bt;
        exp = {8'h55, 8'hAA, 4'h0, bt, seq_m, 8'h00,
               ({4'h0, bt} ^ seq_m)};
        n = 0;
        @(negedge clk);
        while (!bus.fd_send && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, ".fd_send_hi"}, 48'(bus.fd_send), 48'h1);
        got = '1;
        if (txq.size() == 6)
            got = {txq[0], txq[1], txq[2], txq[3], txq[4], txq[5]};
        chk({name, ".nbytes"}, 48'(txq.size()), 48'd6);
        chk({name, ".frame"}, got, exp);
        seq_m = seq_m + 8'd1;
        bus.fs_send = 1'b0;
        @(negedge clk);
        chk({name, ".fd_send_lo"}, 48'(bus.fd_send), 48'h0);
        chk({name, ".tx_valid_lo"}, 48'(bus.tx_valid), 48'h0);
    endtask

    rx_vec_t rx_tab[5];
    tx_vec_t tx_tab[3];

    initial begin
        logic [47:0] f;
        bit ok;
        logic [7:0] bq[$];

        rx_tab[0] = '{48'h55AA02123424, 1'b1, 4'h2, 16'h1234};
        rx_tab[1] = '{48'h55AA02123425, 1'b0, 4'h0, 16'h0000};
        rx_tab[2] = '{48'h55AA12123434, 1'b0, 4'h0, 16'h0000};
        rx_tab[3] = '{48'h55AA0F00FFF0, 1'b1, 4'hF, 16'h00FF};
        rx_tab[4] = '{48'h55AA00000000, 1'b1, 4'h0, 16'h0000};
        tx_tab[0] = '{4'h3, 0};
        tx_tab[1] = '{4'h3, 1};
        tx_tab[2] = '{4'hA, 2};

        bus.fs_send    = 1'b0;
        bus.send_btype = 4'h0;
        bus.fd_read    = 1'b0;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.fd_send", 48'(bus.fd_send), 48'h0);
        chk("rst.fs_read", 48'(bus.fs_read), 48'h0);
        chk("rst.read_btype", 48'(bus.read_btype), 48'h0);
        chk("rst.com_cmd", 48'(bus.com_cmd), 48'h0);
        chk("rst.tx_data", 48'(bus.tx_data), 48'h0);
        chk("rst.tx_valid", 48'(bus.tx_valid), 48'h0);
        check_err();
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            feed(rx_tab[i].frame);
            if (!rx_tab[i].ok) err_m++;
            check_rx($sformatf("rxtab%0d", i), rx_tab[i].ok,
                     rx_tab[i].bt, rx_tab[i].cmd);
        end
        check_err();

        feed(mk(4'h5, 16'hABCD));
        feed(mk(4'h6, 16'h1111));
        err_m++;
        chk("drop.cmd", 48'(bus.com_cmd), 48'hABCD);
        check_rx("drop", 1'b1, 4'h5, 16'hABCD);
        check_err();

        bq = '{8'h55, 8'h55, 8'hAA, 8'h02, 8'h12, 8'h34, 8'h24};
        feed_q(bq);
        check_rx("resync", 1'b1, 4'h2, 16'h1234);

        bq = '{8'h55, 8'hAA, 8'h01};
        feed_q(bq);
        repeat (int'(TO) - 1) @(negedge clk);
        bq = '{8'h12, 8'h34, 8'h27};
        feed_q(bq);
        check_rx("to_edge", 1'b1, 4'h1, 16'h1234);

        bq = '{8'h55, 8'hAA, 8'h01};
        feed_q(bq);
        repeat (int'(TO)) @(negedge clk);
        bq = '{8'h12, 8'h34, 8'h27};
        feed_q(bq);
        err_m++;
        check_rx("timeout", 1'b0, 4'h0, 16'h0);
        check_err();

        for (int i = 0; i < 3; i++) begin
            rdy_mode = tx_tab[i].mode;
            do_send($sformatf("txtab%0d", i), tx_tab[i].bt);
        end

        rdy_mode = 0;
        fork
            do_send("sim_tx", 4'h9);
            begin
                feed(mk(4'h3, 16'hBEEF));
                check_rx("sim_rx", 1'b1, 4'h3, 16'hBEEF);
            end
        join

        bus.fs_send    = 1'b1;
        bus.send_btype = 4'h7;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid.tx_valid", 48'(bus.tx_valid), 48'h0);
        chk("rst_mid.fd_send", 48'(bus.fd_send), 48'h0);
        seq_m = 8'h00;
        err_m = 0;
        bus.fs_send = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_err();
        do_send("after_rst", 4'h4);

        rdy_mode = 2;
        for (int i = 0; i < 30; i++) begin
            f = mk(4'($urandom), 16'($urandom));
            case ($urandom_range(0, 3))
                0: f[31:28] = 4'($urandom_range(1, 15));
                1: f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
                default: ;
            endcase
            ok = ok_of(f);
            if (!ok) err_m++;
            feed(f);
            check_rx($sformatf("rnd%0d", i), ok, f[27:24], f[23:8]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i % 6 == 5)
                do_send($sformatf("rnd_tx%0d", i), 4'($urandom));
        end
        check_err();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
